// File: rtl/sap1_display_pkg.sv
// Shared types and constants for the SAP-1 output display.
// Optional sign support is selected in the top with SAP1_DISPLAY_SINAL_EN.
package sap1_display_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   localparam int SCAN_DIV_DEF = 16;

   // Active-low segment codes, bit 0 = a ... bit 6 = g
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'h3F;

   // Any nibble value >= 10 decodes to blank; this one is used on purpose.
   localparam logic [3:0] NIB_BLANK = 4'hF;

   // Double-dabble correction: add 3 to every BCD nibble that is >= 5.
   function automatic logic [11:0] dd_add3(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      for (int i = 0; i < 3; i++) begin
         if (r[i*4 +: 4] >= 4'd5)
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/display_saida_dec7seg.sv
// BCD digit to active-low 7-segment decoder; codes 10..15 decode to blank.
module dec7seg
   import sap1_display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/display_saida.sv
// SAP-1 output display: iterative binary-to-BCD conversion plus 4-digit multiplexed scan.
// Define SAP1_DISPLAY_SINAL_EN to treat d as two's complement and show a minus sign on digit 3.
module display_saida
   import sap1_display_pkg::*;
#(
   parameter int SCAN_DIV = SCAN_DIV_DEF
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  d,
   input  logic        n_write,
   output logic        busy,
   output logic [11:0] bcd,
   output logic        neg,
   output logic [3:0]  an,
   output logic [6:0]  seg
);

   localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

   state_t      state;
   logic [7:0]  bin_sr;
   logic [11:0] work;
   logic [2:0]  iter;
   logic [7:0]  mag;
   logic [19:0] step;
   logic [11:0] work_nx;
   logic [7:0]  bin_nx;

`ifdef SAP1_DISPLAY_SINAL_EN
   logic neg_cap;
   logic neg_r;

   // 8'h80 negates to itself, which read as unsigned is the wanted 128
   assign mag = d[7] ? 8'(-d) : d;
   assign neg = neg_r;
`else
   assign mag = d;
   assign neg = 1'b0;
`endif

   assign step    = {dd_add3(work), bin_sr} << 1;
   assign work_nx = step[19:8];
   assign bin_nx  = step[7:0];

   // Conversion FSM; a capture always wins, even on the final iteration
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         bcd    <= 12'h000;
         bin_sr <= 8'h00;
         work   <= 12'h000;
         iter   <= 3'd0;
`ifdef SAP1_DISPLAY_SINAL_EN
         neg_cap <= 1'b0;
         neg_r   <= 1'b0;
`endif
      end else if (!n_write) begin
         state  <= CONV;
         busy   <= 1'b1;
         bin_sr <= mag;
         work   <= 12'h000;
         iter   <= 3'd0;
`ifdef SAP1_DISPLAY_SINAL_EN
         neg_cap <= d[7];
`endif
      end else begin
         case (state)
            IDLE: begin
               busy <= 1'b0;
            end
            CONV: begin
               bin_sr <= bin_nx;
               work   <= work_nx;
               iter   <= iter + 3'd1;
               if (iter == 3'd7) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  bcd   <= work_nx;
`ifdef SAP1_DISPLAY_SINAL_EN
                  neg_r <= neg_cap;
`endif
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Digit scanning runs free of the converter
   logic [15:0] scan_cnt;
   logic [1:0]  dig_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= 16'd0;
         dig_idx  <= 2'd0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= 16'd0;
         dig_idx  <= dig_idx + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + 16'd1;
      end
   end

   logic [3:0] hund, tens, units;
   logic [3:0] nib;
   logic [6:0] seg_dec;

   assign hund  = bcd[11:8];
   assign tens  = bcd[7:4];
   assign units = bcd[3:0];

   // Leading-zero suppression happens here so a single decoder serves all digits
   always_comb begin
      nib = NIB_BLANK;
      case (dig_idx)
         2'd0:    nib = units;
         2'd1:    nib = (hund == 4'd0 && tens == 4'd0) ? NIB_BLANK : tens;
         2'd2:    nib = (hund == 4'd0) ? NIB_BLANK : hund;
         default: nib = NIB_BLANK;
      endcase
   end

   dec7seg u_dec7seg (
      .bcd (nib),
      .seg (seg_dec)
   );

`ifdef SAP1_DISPLAY_SINAL_EN
   assign seg = (dig_idx == 2'd3 && neg_r) ? SEG_MINUS : seg_dec;
`else
   assign seg = seg_dec;
`endif

   assign an = ~(4'b0001 << dig_idx);

endmodule
